matrix_scan_driver: RTL

Parametrised, time-multiplexed scan driver for a COLS x ROWS LED matrix (5x7 in the irrigation panel) with FRAMES stored images. It adds a per-column prescaler, anti-ghosting blanking, tear-free shadow buffering, automatic or manual frame selection and configurable output polarity. It sits between the image-generation logic and the matrix pins and replaces the fixed 5x7 column selector.

---
 rtl/matrix_scan_driver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_driver.sv
`timescale 1ns/1ps
// matrix_scan_driver
// Time-multiplexed column scan for a COLS x ROWS LED matrix holding FRAMES
// images. Each column slot lasts SCAN_DIV cycles; the first BLANK_CYCLES of
// every slot are blanked to prevent ghosting. Pixel data and frame selection
// are latched into a shadow buffer only at frame boundaries, so a frame is
// never torn. Outputs are registered and carry the configured polarity.
module matrix_scan_driver #(
  parameter int COLS           = 5,
  parameter int ROWS           = 7,
  parameter int FRAMES         = 2,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int ALT_FRAMES     = 250,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int IW = FRAMES * COLS * ROWS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [FW-1:0]   frame_sel,
  input  logic [IW-1:0]   image_data,
  output logic [COLS-1:0] matrix_col,
  output logic [ROWS-1:0] matrix_row,
  output logic [FW-1:0]   current_frame,
  output logic            frame_start
);

  // Counter widths.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(COLS);
  localparam int AW = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam int NW = FRAMES * COLS;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

  // Terminal counts.
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  // Idle (inactive) pin levels; XOR-ing an active-high pattern with these
  // applies the output polarity.
  localparam logic [COLS-1:0] COL_IDLE = {COLS{COL_ACTIVE_LOW != 0}};
  localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{ROW_ACTIVE_LOW != 0}};

  // Active frame-selection policy latched at each boundary.
  typedef enum logic [1:0] {
    SEL_STATIC = 2'd0,
    SEL_AUTO   = 2'd1,
    SEL_MANUAL = 2'd2
  } sel_t;

  // State registers and their next values.
  logic [PW-1:0]   presc_reg,        presc_next;
  logic [CW-1:0]   col_reg,          col_next;
  logic [AW-1:0]   alt_reg,          alt_next;
  logic [FW-1:0]   frame_reg,        frame_next;
  sel_t            sel_reg,          sel_next;
  logic            load_pending_reg, load_pending_next;
  logic [IW-1:0]   shadow_reg,       shadow_next;
  logic [COLS-1:0] col_out_reg,      col_out_next;
  logic [ROWS-1:0] row_out_reg,      row_out_next;
  logic            frame_start_reg,  frame_start_next;

  // Decoded request and timing strobes.
  sel_t            req_sel;
  logic [FW-1:0]   manual_frame;
  logic            tick;
  logic            boundary;
  logic            sample;
  logic            drive;
  logic [COLS-1:0] col_hot;
  logic [WW-1:0]   word_idx;
  logic [ROWS-1:0] col_words [NW];

  // One-hot (active-high) column decode of the scan index.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_hot
      assign col_hot[gi] = (col_reg == CW'(gi));
    end
  endgenerate

  // View the shadow buffer as one ROWS-wide word per (frame, column).
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_col_words
      assign col_words[gi] = shadow_reg[gi*ROWS +: ROWS];
    end
  endgenerate

  // Decode the mode pins and clamp an out-of-range manual frame index.
  always_comb begin
    req_sel      = SEL_STATIC;
    manual_frame = frame_sel;
    if (FRAMES > 1) begin
      case (mode)
        2'b01:   req_sel = SEL_AUTO;
        2'b10:   req_sel = SEL_MANUAL;
        default: req_sel = SEL_STATIC;
      endcase
    end
    if (32'(frame_sel) > 32'(FRAMES - 1)) begin
      manual_frame = FRAME_LAST;
    end
  end

  // Slot timing: prescaler tick, frame boundary and selection sampling.
  always_comb begin
    tick     = enable && (presc_reg == PRESC_LAST);
    boundary = tick && (col_reg == COL_LAST);
    sample   = enable && (load_pending_reg || boundary);
    drive    = enable && (int'(presc_reg) >= BLANK_CYCLES);
    word_idx = WW'(int'(frame_reg) * COLS + int'(col_reg));
  end

  // Next-state for the scan counters, frame selection and shadow buffer.
  always_comb begin
    presc_next        = presc_reg;
    col_next          = col_reg;
    alt_next          = alt_reg;
    frame_next        = frame_reg;
    sel_next          = sel_reg;
    load_pending_next = load_pending_reg;
    shadow_next       = shadow_reg;

    if (enable) begin
      load_pending_next = 1'b0;
      if (tick) begin
        presc_next = '0;
        col_next   = (col_reg == COL_LAST) ? '0 : col_reg + CW'(1);
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end

    // While the display is off the shadow tracks the input so the first
    // frame after re-enable is current.
    if (!enable || sample) begin
      shadow_next = image_data;
    end

    if (sample) begin
      sel_next = req_sel;
      case (req_sel)
        SEL_AUTO: begin
          if (sel_reg != SEL_AUTO) begin
            // Entering auto: start counting afresh from the shown frame.
            alt_next = '0;
          end else if (alt_reg == ALT_LAST) begin
            alt_next   = '0;
            frame_next = (frame_reg == FRAME_LAST) ? '0 : frame_reg + FW'(1);
          end else begin
            alt_next = alt_reg + AW'(1);
          end
        end
        SEL_MANUAL: begin
          alt_next   = '0;
          frame_next = manual_frame;
        end
        default: begin
          alt_next   = '0;
          frame_next = '0;
        end
      endcase
    end
  end

  // Registered pin drive: blank window and disable force the idle levels.
  always_comb begin
    col_out_next     = COL_IDLE;
    row_out_next     = ROW_IDLE;
    frame_start_next = boundary;
    if (drive) begin
      col_out_next = col_hot ^ COL_IDLE;
      row_out_next = col_words[word_idx] ^ ROW_IDLE;
    end
  end

  // State register with synchronous reset that overrides every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_reg        <= '0;
      col_reg          <= '0;
      alt_reg          <= '0;
      frame_reg        <= '0;
      sel_reg          <= SEL_STATIC;
      load_pending_reg <= 1'b1;
      shadow_reg       <= '0;
      col_out_reg      <= COL_IDLE;
      row_out_reg      <= ROW_IDLE;
      frame_start_reg  <= 1'b0;
    end else begin
      presc_reg        <= presc_next;
      col_reg          <= col_next;
      alt_reg          <= alt_next;
      frame_reg        <= frame_next;
      sel_reg          <= sel_next;
      load_pending_reg <= load_pending_next;
      shadow_reg       <= shadow_next;
      col_out_reg      <= col_out_next;
      row_out_reg      <= row_out_next;
      frame_start_reg  <= frame_start_next;
    end
  end

  assign matrix_col    = col_out_reg;
  assign matrix_row    = row_out_reg;
  assign current_frame = frame_reg;
  assign frame_start   = frame_start_reg;

endmodule
